rssb_seq: RTL

- Instruction sequencer for the 1-bit RSSB (reverse-subtract, skip-if-borrow) core.
- Per instruction it fetches the operand address from instruction memory, reads the data-memory operand, and hands operand and accumulator to the ALU.
- It then writes the result back to data memory and the accumulator, and advances pc by 1, or by 2 on borrow.
- Each retired instruction is logged into a LEN-deep trace FIFO drained by a valid/ready consumer.

---
 rtl/rssb_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/rssb_seq.sv
// rssb_seq: fetch/read/exec/write-back sequencer for the 1-bit RSSB core with a retired-instruction trace FIFO
module rssb_seq #(
  parameter int BW = 1,
  parameter int IW = 4,
  parameter int DW = 4,
  parameter int LEN = 4,
  parameter int PTR = 2,
  parameter logic [DW-1:0] HALT_OP = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          halted,
  output logic [IW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] dmem_raddr,
  input  logic [BW-1:0] dmem_rdata,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_waddr,
  output logic [BW-1:0] dmem_wdata,
  output logic          alu_ena,
  output logic [BW-1:0] alu_a,
  output logic [BW-1:0] alu_b,
  input  logic          alu_valid,
  input  logic [BW-1:0] alu_result,
  input  logic          alu_borrow,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [IW-1:0] trace_pc,
  output logic [BW-1:0] trace_data,
  output logic          trace_skip,
  output logic [BW-1:0] acc
);
  typedef enum logic [2:0] {IDLE, FETCH, READ, EXEC, WB, HALT} state_t;
  state_t state, nxt;
  logic [IW-1:0] pc;
  logic [DW-1:0] ir;
  logic [BW-1:0] opnd, res;
  logic brw, push, pop;
  logic [PTR-1:0] ptr_old, ptr_young;
  logic [PTR:0] count;
  logic [BW+IW:0] fifo [LEN];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? FETCH : IDLE;
      FETCH: nxt = (imem_rdata == HALT_OP) ? HALT : READ;
      READ:  nxt = EXEC;
      EXEC:  nxt = alu_valid ? WB : EXEC;
      WB:    nxt = push ? FETCH : WB;
      HALT:  nxt = start ? FETCH : HALT;
      default: nxt = IDLE;
    endcase
  end
  // a full FIFO still accepts the push when the head leaves in the same cycle
  always_comb begin
    busy = state inside {FETCH, READ, EXEC, WB};
    halted = state == HALT;
    alu_ena = state == EXEC;
    trace_valid = count != '0;
    pop = trace_valid & trace_ready;
    push = (state == WB) && (!count[PTR] || pop);
    dmem_we = push;
  end
  assign imem_addr = pc;
  assign dmem_raddr = ir;
  assign dmem_waddr = ir;
  assign dmem_wdata = res;
  assign alu_a = opnd;
  assign alu_b = acc;
  assign {trace_data, trace_pc, trace_skip} = fifo[ptr_old];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= '0;
      acc <= '0;
      ir <= '0;
      opnd <= '0;
      res <= '0;
      brw <= 1'b0;
      ptr_old <= '0;
      ptr_young <= '0;
      count <= '0;
    end else begin
      if (state == FETCH && imem_rdata != HALT_OP) ir <= imem_rdata;
      if (state == READ) opnd <= dmem_rdata;
      if (alu_ena && alu_valid) begin
        res <= alu_result;
        brw <= alu_borrow;
      end
      if (push) begin
        acc <= res;
        pc <= pc + (brw ? IW'(2) : IW'(1));
        ptr_young <= ptr_young + PTR'(1);
      end
      if (state == HALT && start) begin
        pc <= '0;
        acc <= '0;
      end
      if (pop) ptr_old <= ptr_old + PTR'(1);
      count <= count + (PTR+1)'(push) - (PTR+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) fifo[ptr_young] <= {res, pc, brw};
endmodule
